data_memory_banked: RTL



---
 rtl/data_memory_banked_if.sv | 46 ++++
 rtl/data_memory_banked.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_banked_if.sv
// rtl/data_memory_banked_if.sv - request/response bundle for data_memory_banked
//
// Purpose: groups the access handshake, the request fields and the completion
//          fields of the banked data memory into one interface.
// Signals:
//   req          access request (master -> slave)
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld  1 = zero-extend load, 0 = sign-extend load
//   addr         byte address
//   wdata        store data, right-justified
//   inj_perr     test hook: corrupt stored parity of the written lanes
//   ready        slave idle, req will be sampled
//   done         one-cycle completion pulse
//   rdata        load result, held until the next completion
//   err          access error, qualified by done
//   perr         parity error, qualified by done
// Modports: master drives the request side, slave drives the completion side.

interface data_memory_banked_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [1:0]            size;
   logic                  unsigned_ld;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  inj_perr;
   logic                  ready;
   logic                  done;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;
   logic                  perr;

   modport master (
      output req, we, size, unsigned_ld, addr, wdata, inj_perr,
      input  ready, done, rdata, err, perr
   );

   modport slave (
      input  req, we, size, unsigned_ld, addr, wdata, inj_perr,
      output ready, done, rdata, err, perr
   );
endinterface

// File: rtl/data_memory_banked.sv
// rtl/data_memory_banked.sv - byte-addressable data memory with req/ready/done handshake
//
// Purpose: byte/half/word loads and stores on a little-endian word array with a
//          configurable number of wait cycles per access. Misaligned, reserved-size
//          and out-of-range accesses complete immediately with err=1 and have no
//          effect on the array or on rdata.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears FSM, outputs and the whole array
//   bus    data_memory_banked_if.slave (req/we/size/unsigned_ld/addr/wdata/inj_perr in,
//          ready/done/rdata/err/perr out)
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per byte,
//          honour inj_perr on stores and report perr on loads. Without it perr is 0.

module data_memory_banked #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LATENCY    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   data_memory_banked_if.slave  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDX   = $clog2(DEPTH);
   localparam int TOP   = OFF + IDX;
   localparam logic [2:0] LAT = 3'(LATENCY);
   localparam logic ZERO_LAT = (LATENCY == 0);
   localparam logic [DATA_WIDTH-1:0] B_MASK = DATA_WIDTH'(8'hFF);
   localparam logic [DATA_WIDTH-1:0] H_MASK = DATA_WIDTH'(16'hFFFF);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;

   // Captured request fields
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [TOP-1:0]        addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  aerr_q;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  perr_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  idle;
   logic                  accept;
   logic                  in_oor;
   logic                  in_err;
   logic                  enter_done;
   logic                  do_access;

   // Effective access fields: live bus values on the acceptance edge, captured
   // values afterwards. This lets a zero-latency access complete on edge 0.
   logic                  cur_we;
   logic [1:0]            cur_size;
   logic                  cur_uns;
   logic [TOP-1:0]        cur_addr;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic                  cur_err;
   logic [IDX-1:0]        cur_idx;
   logic [OFF-1:0]        cur_off;

   logic [BYTES-1:0]      lane_mask;
   logic [DATA_WIDTH-1:0] wlane;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] sh;
   logic [DATA_WIDTH-1:0] ld_val;
   logic                  par_mm;

   assign idle   = (state_q == S_IDLE);
   assign accept = idle && bus.req;

   // ---------------------------------------------------------------- checks
   if (ADDR_WIDTH > TOP) begin : g_range
      assign in_oor = |bus.addr[ADDR_WIDTH-1:TOP];
   end else begin : g_norange
      assign in_oor = 1'b0;
   end

   always_comb begin
      in_err = 1'b0;
      case (bus.size)
         2'b01:   in_err = bus.addr[0];
         2'b10:   in_err = |bus.addr[OFF-1:0];
         2'b11:   in_err = 1'b1;
         default: in_err = 1'b0;
      endcase
      if (in_oor) begin
         in_err = 1'b1;
      end
   end

   assign cur_we    = idle ? bus.we             : we_q;
   assign cur_size  = idle ? bus.size           : size_q;
   assign cur_uns   = idle ? bus.unsigned_ld    : uns_q;
   assign cur_addr  = idle ? bus.addr[TOP-1:0]  : addr_q;
   assign cur_wdata = idle ? bus.wdata          : wdata_q;
   assign cur_err   = idle ? in_err             : aerr_q;
   assign cur_idx   = cur_addr[TOP-1:OFF];
   assign cur_off   = cur_addr[OFF-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               if (ZERO_LAT || in_err) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = LAT;
               end
            end
         end
         S_WAIT: begin
            // Leaving on cnt_q==1 puts DONE at edge LATENCY.
            if (cnt_q <= 3'd1) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // DONE always returns to IDLE, so any DONE next-state is an entry edge.
   assign enter_done = (state_d == S_DONE);
   assign do_access  = enter_done && !cur_err;

   // ---------------------------------------------------------------- capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         aerr_q  <= 1'b0;
      end else if (accept) begin
         we_q    <= bus.we;
         size_q  <= bus.size;
         uns_q   <= bus.unsigned_ld;
         addr_q  <= bus.addr[TOP-1:0];
         wdata_q <= bus.wdata;
         aerr_q  <= in_err;
      end
   end

   // ---------------------------------------------------------------- lanes
   always_comb begin
      lane_mask = '0;
      case (cur_size)
         2'b00:   lane_mask = BYTES'(1) << cur_off;
         2'b01:   lane_mask = BYTES'(3) << cur_off;
         default: lane_mask = '1;
      endcase
   end

   // Replicating the right-justified data across the word means every lane
   // already holds the right bytes; the mask picks which ones land.
   always_comb begin
      wlane = cur_wdata;
      case (cur_size)
         2'b00:   wlane = {BYTES{cur_wdata[7:0]}};
         2'b01:   wlane = {(BYTES/2){cur_wdata[15:0]}};
         default: wlane = cur_wdata;
      endcase
   end

   assign rd_word = mem_q[cur_idx];
   assign sh      = rd_word >> {cur_off, 3'b000};

   always_comb begin
      ld_val = sh;
      case (cur_size)
         2'b00:   ld_val = (sh & B_MASK) | ((!cur_uns && sh[7])  ? ~B_MASK : '0);
         2'b01:   ld_val = (sh & H_MASK) | ((!cur_uns && sh[15]) ? ~H_MASK : '0);
         default: ld_val = sh;
      endcase
   end

   // ---------------------------------------------------------------- array
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (do_access && cur_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (lane_mask[b]) begin
               mem_q[cur_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
         end
      end
   end

`ifdef DMEM_PARITY_EN
   logic             inj_q;
   logic             cur_inj;
   logic [BYTES-1:0] par_q [DEPTH];

   assign cur_inj = idle ? bus.inj_perr : inj_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inj_q <= 1'b0;
      end else if (accept) begin
         inj_q <= bus.inj_perr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < DEPTH; w++) begin
            par_q[w] <= '0;
         end
      end else if (do_access && cur_we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (lane_mask[b]) begin
               par_q[cur_idx][b] <= (^wlane[8*b +: 8]) ^ cur_inj;
            end
         end
      end
   end

   always_comb begin
      par_mm = 1'b0;
      for (int b = 0; b < BYTES; b++) begin
         if (lane_mask[b] && ((^rd_word[8*b +: 8]) != par_q[cur_idx][b])) begin
            par_mm = 1'b1;
         end
      end
   end
`else
   logic unused_inj;
   assign unused_inj = bus.inj_perr;
   assign par_mm     = 1'b0;
`endif

   // ---------------------------------------------------------------- result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         perr_q  <= 1'b0;
      end else if (enter_done) begin
         perr_q <= do_access && !cur_we && par_mm;
         if (do_access && !cur_we) begin
            rdata_q <= ld_val;
         end
      end
   end

   assign bus.ready = idle;
   assign bus.done  = (state_q == S_DONE);
   assign bus.rdata = rdata_q;
   assign bus.err   = (state_q == S_DONE) && aerr_q;
   assign bus.perr  = (state_q == S_DONE) && perr_q;

endmodule
